// File: rtl/pwm_tick_gen_pkg.sv
// Shared encodings and sizing helpers for the multi-channel PWM/tick generator.
// Imported by pwm_tick_gen and pwm_channel.
package pwm_tick_gen_pkg;

    typedef enum logic [1:0] {
        CFG_SEL_PERIOD = 2'b00,
        CFG_SEL_DUTY   = 2'b01,
        CFG_SEL_PRESC  = 2'b10,
        CFG_SEL_RSVD   = 2'b11
    } cfg_sel_e;

    // A single channel still needs a 1-bit select port.
    function automatic int ch_idx_w(input int ch);
        return (ch <= 1) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active period+duty, counter, compare and wrap tick.
// Shadow values move to active on wrap, or continuously while disabled.
module pwm_channel #(
    parameter int W          = 16,
    parameter int DEF_PERIOD = 19,
    parameter int DEF_DUTY   = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         ce,
    input  logic         wr_period,
    input  logic         wr_duty,
    input  logic [W-1:0] data,
    output logic         pwm,
    output logic         tick,
    output logic [W-1:0] cnt
);

    logic [W-1:0] per_sh;
    logic [W-1:0] duty_sh;
    logic [W-1:0] per_act;
    logic [W-1:0] duty_act;
    logic         wrap;
    logic [W-1:0] cnt_nx;
    logic [W-1:0] duty_nx;

    always_comb begin
        wrap    = (cnt == per_act);
        cnt_nx  = wrap ? '0 : cnt + 1'b1;
        duty_nx = wrap ? duty_sh : duty_act;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_sh  <= W'(DEF_PERIOD);
            duty_sh <= W'(DEF_DUTY);
        end else begin
            if (wr_period) per_sh  <= data;
            if (wr_duty)   duty_sh <= data;
        end
    end

    // Active reads the registered shadow, so a same-edge write lands one wrap later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_act  <= W'(DEF_PERIOD);
            duty_act <= W'(DEF_DUTY);
            cnt      <= '0;
            pwm      <= 1'b0;
            tick     <= 1'b0;
        end else if (!en) begin
            per_act  <= per_sh;
            duty_act <= duty_sh;
            cnt      <= '0;
            pwm      <= 1'b0;
            tick     <= 1'b0;
        end else if (ce) begin
            cnt  <= cnt_nx;
            pwm  <= (cnt_nx < duty_nx);
            tick <= wrap;
            if (wrap) begin
                per_act  <= per_sh;
                duty_act <= duty_sh;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_tick_gen.sv
// Multi-channel PWM/tick generator: config decode plus optional shared prescaler.
// Define PWM_PRESCALE_EN to build the prescaler (cfg_sel=10); otherwise ce is tied high.
module pwm_tick_gen
    import pwm_tick_gen_pkg::*;
#(
    parameter int CH         = 4,
    parameter int W          = 16,
    parameter int DEF_PERIOD = 19,
    parameter int DEF_DUTY   = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CH-1:0]             ch_en,
    input  logic                      cfg_we,
    input  logic [ch_idx_w(CH)-1:0]   cfg_ch,
    input  logic [1:0]                cfg_sel,
    input  logic [W-1:0]              cfg_data,
    output logic [CH-1:0]             pwm_out,
    output logic [CH-1:0]             tick,
    output logic [W-1:0]              cnt_ch0
);

    localparam int CW = ch_idx_w(CH);

    logic [31:0]  ch_ext;
    logic         ch_ok;
    logic         wr_period;
    logic         wr_duty;
    logic         ce;
    logic [W-1:0] cnt_all [CH];

    assign ch_ext    = 32'(cfg_ch);
    assign ch_ok     = ch_ext < 32'(CH);
    assign wr_period = cfg_we && ch_ok && (cfg_sel == CFG_SEL_PERIOD);
    assign wr_duty   = cfg_we && ch_ok && (cfg_sel == CFG_SEL_DUTY);
    assign cnt_ch0   = cnt_all[0];

`ifdef PWM_PRESCALE_EN
    logic [W-1:0] presc;
    logic [W-1:0] pcnt;
    logic         wr_presc;

    assign wr_presc = cfg_we && (cfg_sel == CFG_SEL_PRESC);
    assign ce       = (pcnt == presc);

    // A new divide ratio restarts the phase so the first ce is predictable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            pcnt  <= '0;
        end else if (wr_presc) begin
            presc <= cfg_data;
            pcnt  <= '0;
        end else begin
            pcnt <= ce ? '0 : pcnt + 1'b1;
        end
    end
`else
    assign ce = 1'b1;
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic hit;
        assign hit = (cfg_ch == CW'(i));

        pwm_channel #(
            .W          (W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_DUTY   (DEF_DUTY)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .en        (ch_en[i]),
            .ce        (ce),
            .wr_period (wr_period && hit),
            .wr_duty   (wr_duty && hit),
            .data      (cfg_data),
            .pwm       (pwm_out[i]),
            .tick      (tick[i]),
            .cnt       (cnt_all[i])
        );
    end

endmodule

// File: tb/tb_pwm_tick_gen.sv
// Self-checking bench for pwm_tick_gen: vector table, directed corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_pwm_tick_gen;

    localparam int CH = 4;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] ch_en;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [1:0]    cfg_sel;
    logic [W-1:0]  cfg_data;
    logic [CH-1:0] pwm_out;
    logic [CH-1:0] tick;
    logic [W-1:0]  cnt_ch0;

    pwm_tick_gen #(
        .CH(CH), .W(W), .DEF_PERIOD(19), .DEF_DUTY(10)
    ) dut (
        .clk(clk), .reset(reset), .ch_en(ch_en), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .pwm_out(pwm_out), .tick(tick), .cnt_ch0(cnt_ch0)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int m_cnt [CH];
    int m_pa  [CH];
    int m_da  [CH];
    int m_ps  [CH];
    int m_ds  [CH];
    int m_pwm [CH];
    int m_tick[CH];
    int m_presc;
    int m_pc;

    typedef struct {
        int ch;
        int period;
        int duty;
        int cycles;
        int exp_high;
        int exp_ticks;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i] = 0;  m_pa[i] = 19; m_ps[i] = 19;
            m_da[i] = 10;  m_ds[i] = 10;
            m_pwm[i] = 0;  m_tick[i] = 0;
        end
        m_presc = 0;
        m_pc    = 0;
    endtask

    // One clock edge of the spec's rules, using the inputs present at that edge.
    task automatic model_edge();
        int ce;
        ce = 1;
`ifdef PWM_PRESCALE_EN
        ce   = (m_pc == m_presc) ? 1 : 0;
        m_pc = ce ? 0 : m_pc + 1;
`endif
        for (int i = 0; i < CH; i++) begin
            if (!ch_en[i]) begin
                m_cnt[i] = 0; m_pwm[i] = 0; m_tick[i] = 0;
                m_pa[i] = m_ps[i]; m_da[i] = m_ds[i];
            end else if (ce != 0) begin
                if (m_cnt[i] == m_pa[i]) begin
                    m_cnt[i] = 0; m_tick[i] = 1;
                    m_pa[i] = m_ps[i]; m_da[i] = m_ds[i];
                end else begin
                    m_cnt[i] = m_cnt[i] + 1; m_tick[i] = 0;
                end
                m_pwm[i] = (m_cnt[i] < m_da[i]) ? 1 : 0;
            end else begin
                m_tick[i] = 0;
            end
        end
        if (cfg_we) begin
            int c;
            c = int'(cfg_ch);
            case (cfg_sel)
                2'b00: if (c < CH) m_ps[c] = int'(cfg_data);
                2'b01: if (c < CH) m_ds[c] = int'(cfg_data);
                2'b10: begin
`ifdef PWM_PRESCALE_EN
                    m_presc = int'(cfg_data);
                    m_pc    = 0;
`endif
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < CH; i++) begin
            check($sformatf("pwm_out[%0d]", i), int'(pwm_out[i]), m_pwm[i]);
            check($sformatf("tick[%0d]", i), int'(tick[i]), m_tick[i]);
        end
        check("cnt_ch0", int'(cnt_ch0), m_cnt[0]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic write(input int ch, input int sel, input int data);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_sel  = 2'(sel);
        cfg_data = W'(data);
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        ch_en  = '0;
        cfg_we = 1'b0;
        cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset pwm_out", int'(pwm_out), 0);
        check("reset tick", int'(tick), 0);
        check("reset cnt_ch0", int'(cnt_ch0), 0);
        reset = 1'b0;
    endtask

    // Steps until tick[ch]; n = cycles taken (-1 on timeout), highs = pwm_out[ch] count.
    task automatic wait_tick(input int ch, input int max, output int n, output int highs);
        n = -1;
        highs = 0;
        for (int k = 1; k <= max; k++) begin
            step();
            highs += int'(pwm_out[ch]);
            if (tick[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n, h, hi, tk, gap;

        reset = 1'b1;
        ch_en = '0;
        cfg_we = 1'b0;
        cfg_ch = '0; cfg_sel = '0; cfg_data = '0;

        vecs[0] = '{ch:0, period:19, duty:10, cycles:200, exp_high:100, exp_ticks:10};
        vecs[1] = '{ch:1, period:9,  duty:3,  cycles:100, exp_high:30,  exp_ticks:10};
        vecs[2] = '{ch:2, period:19, duty:0,  cycles:100, exp_high:0,   exp_ticks:5};
        vecs[3] = '{ch:3, period:19, duty:25, cycles:100, exp_high:100, exp_ticks:5};
        vecs[4] = '{ch:0, period:0,  duty:5,  cycles:40,  exp_high:40,  exp_ticks:40};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            write(vecs[v].ch, 0, vecs[v].period);
            write(vecs[v].ch, 1, vecs[v].duty);
            step();
            step();
            ch_en = CH'(1 << vecs[v].ch);
            hi = 0;
            tk = 0;
            for (int k = 0; k < vecs[v].cycles; k++) begin
                step();
                hi += int'(pwm_out[vecs[v].ch]);
                tk += int'(tick[vecs[v].ch]);
            end
            check($sformatf("vec%0d high cycles", v), hi, vecs[v].exp_high);
            check($sformatf("vec%0d ticks", v), tk, vecs[v].exp_ticks);
        end

        // Defaults on ch0: 10 high / 10 low, tick every 20; others idle.
        do_reset();
        ch_en = 4'b0001;
        wait_tick(0, 40, n, h);
        check("default first tick", n, 20);
        wait_tick(0, 40, n, h);
        check("default tick gap", n, 20);
        check("default highs", h, 10);
        check("default idle channels", int'(pwm_out[3:1]), 0);

        // Mid-period update on ch1 only takes effect after the current wrap.
        do_reset();
        ch_en = 4'b0010;
        wait_tick(1, 40, n, h);
        repeat (5) step();
        write(1, 0, 9);
        write(1, 1, 3);
        wait_tick(1, 40, n, h);
        check("update old period remainder", n, 13);
        wait_tick(1, 40, n, h);
        check("update new period", n, 10);
        check("update new highs", h, 3);

        // Duty write on the exact wrap edge: old duty next period, new after.
        do_reset();
        ch_en = 4'b0001;
        for (int k = 0; k < 40 && m_cnt[0] != m_pa[0]; k++) step();
        write(0, 1, 5);
        check("collision wrap edge tick", int'(tick[0]), 1);
        wait_tick(0, 40, n, h);
        check("collision next period len", n, 20);
        check("collision next highs", h, 10);
        wait_tick(0, 40, n, h);
        check("collision following highs", h, 5);

        // Disable mid-count: cleared next edge, no tick.
        do_reset();
        ch_en = 4'b0101;
        repeat (7) step();
        check("pre-disable cnt_ch0", int'(cnt_ch0), 7);
        ch_en = 4'b0000;
        step();
        check("disable cnt_ch0", int'(cnt_ch0), 0);
        check("disable tick", int'(tick), 0);
        check("disable pwm", int'(pwm_out), 0);

        // Asynchronous reset in the middle of a clock cycle.
        do_reset();
        ch_en = 4'b1111;
        write(2, 1, 2);
        repeat (5) step();
        check("pre-reset pwm", int'(pwm_out[0]), 1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async reset pwm", int'(pwm_out), 0);
        check("async reset cnt", int'(cnt_ch0), 0);
        reset = 1'b0;
        wait_tick(2, 40, n, h);
        check("post-reset period ch2", n, 20);
        check("post-reset duty ch2", h, 10);

        // Prescaler write of 3: PWM period 80 clk when built in, unchanged otherwise.
        do_reset();
        write(0, 2, 3);
        ch_en = 4'b0001;
        wait_tick(0, 200, n, h);
        wait_tick(0, 200, gap, h);
`ifdef PWM_PRESCALE_EN
        check("prescale tick gap", gap, 80);
        check("prescale highs", h, 40);
`else
        check("prescale ignored gap", gap, 20);
        check("prescale ignored highs", h, 10);
`endif
        step();
        check("tick one clk wide", int'(tick[0]), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) ch_en = CH'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                cfg_we  = 1'b1;
                cfg_ch  = 2'($urandom_range(0, 3));
                cfg_sel = 2'($urandom_range(0, 3));
                case (cfg_sel)
                    2'b00:   cfg_data = W'($urandom_range(0, 30));
                    2'b01:   cfg_data = W'($urandom_range(0, 35));
                    default: cfg_data = W'($urandom_range(0, 3));
                endcase
            end else begin
                cfg_we = 1'b0;
            end
            step();
        end
        cfg_we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
